// File: rtl/comparador_pkg.sv
// Shared types and defaults for the comparador arbiter slice.
package comparador_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int DATA_W_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        RESPOND = 2'd2
    } state_t;

    // Width of a requester index; never below one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/comparador_arbiter_if.sv
// Request/response bus between the requesters and the comparador arbiter.
interface comparador_arbiter_if import comparador_pkg::*; #(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int DATA_W  = DATA_W_DEF
);
    localparam int ID_W = id_width(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic                      rsp_c;
    logic [ID_W-1:0]           rsp_id;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_c, rsp_id
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_c, rsp_id
    );

endinterface

// File: rtl/comparador_arbiter_comparador.sv
// Unsigned magnitude comparator: c is 1 only when a is strictly greater than b.
module comparador import comparador_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              c
);

    assign c = (a > b);

endmodule

// File: rtl/comparador_arbiter.sv
// Round-robin arbiter sharing one comparador among NUM_REQ requesters.
// Optional statistics counter enabled by defining COMPARADOR_ARB_STATS_EN.
module comparador_arbiter import comparador_pkg::*; #(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    comparador_arbiter_if.slave  bus,
    output logic [15:0]          cmp_count
);

    localparam int ID_W = id_width(NUM_REQ);

    state_t              state;
    logic [ID_W-1:0]     ptr;
    logic [ID_W-1:0]     cand;
    logic [ID_W-1:0]     gnt_idx;
    logic                gnt_any;
    logic [NUM_REQ-1:0]  ready_c;
    logic [DATA_W-1:0]   sel_a;
    logic [DATA_W-1:0]   sel_b;
    logic [DATA_W-1:0]   op_a;
    logic [DATA_W-1:0]   op_b;
    logic                cmp_c;
    logic                rsp_valid_q;
    logic                rsp_c_q;
    logic [ID_W-1:0]     rsp_id_q;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((int'(ptr) + k) % NUM_REQ);
            if (!gnt_any && bus.req_valid[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
        ready_c = '0;
        if (state == IDLE && !rst && gnt_any) begin
            ready_c[gnt_idx] = 1'b1;
        end
    end

    // Operand mux selecting the winning requester's a/b slices.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == ID_W'(i)) begin
                sel_a = bus.req_a[i*DATA_W +: DATA_W];
                sel_b = bus.req_b[i*DATA_W +: DATA_W];
            end
        end
    end

    // Operand capture on grant; pure data, so no reset needed.
    always_ff @(posedge clk) begin
        if (state == IDLE && gnt_any) begin
            op_a <= sel_a;
            op_b <= sel_b;
        end
    end

    comparador #(.DATA_W(DATA_W)) u_cmp (
        .a (op_a),
        .b (op_b),
        .c (cmp_c)
    );

    // Control FSM: grant, register comparator result, hold until accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= ID_W'(NUM_REQ - 1);
            rsp_valid_q <= 1'b0;
            rsp_c_q     <= 1'b0;
            rsp_id_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_any) begin
                        ptr      <= gnt_idx;
                        rsp_id_q <= gnt_idx;
                        state    <= COMPARE;
                    end
                end
                COMPARE: begin
                    rsp_c_q     <= cmp_c;
                    rsp_valid_q <= 1'b1;
                    state       <= RESPOND;
                end
                RESPOND: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = ready_c;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_c     = rsp_c_q;
    assign bus.rsp_id    = rsp_id_q;

`ifdef COMPARADOR_ARB_STATS_EN
    // Saturating increment so the counter sticks at its maximum.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] cnt_q;

    // Count accepted responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (rsp_valid_q && bus.rsp_ready) begin
            cnt_q <= sat_inc(cnt_q);
        end
    end

    assign cmp_count = cnt_q;
`else
    assign cmp_count = 16'd0;
`endif

endmodule

// File: tb/tb_comparador_arbiter.sv
// Randomized self-checking bench for comparador_arbiter against a
// transaction-level model (pending-response queue with due cycles).
module tb_comparador_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    typedef struct {
        int   id;
        logic c;
        int   due;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cmp_count;

    comparador_arbiter_if #(.NUM_REQ(N), .DATA_W(W)) bus ();

    comparador_arbiter #(.NUM_REQ(N), .DATA_W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .cmp_count (cmp_count)
    );

    always #5 clk = ~clk;

    txn_t        q[$];
    int          last    = N - 1;
    int          cyc     = 0;
    int          n_chk   = 0;
    int          n_err   = 0;
    logic [15:0] exp_cnt = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [W-1:0] opnd(input logic [N*W-1:0] x, input int i);
        return x[i*W +: W];
    endfunction

    // One clock of stimulus plus all checks for that cycle.
    task automatic step(input logic [N-1:0] v, input logic [N*W-1:0] a,
                        input logic [N*W-1:0] b, input logic rr);
        int g;
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        bus.req_valid = v;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.rsp_ready = rr;
        #1;
        g       = -1;
        exp_rdy = '0;
        if (q.size() == 0) begin
            for (int k = 1; k <= N; k++) begin
                int idx;
                idx = (last + k) % N;
                if (g < 0 && v[idx]) g = idx;
            end
        end
        if (g >= 0) exp_rdy[g] = 1'b1;
        check_eq("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
        if (q.size() > 0 && cyc >= q[0].due) begin
            check_eq("rsp_valid", 32'(bus.rsp_valid), 32'd1);
            check_eq("rsp_c", 32'(bus.rsp_c), 32'(q[0].c));
            check_eq("rsp_id", 32'(bus.rsp_id), 32'(q[0].id));
            if (rr) begin
                void'(q.pop_front());
`ifdef COMPARADOR_ARB_STATS_EN
                if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
`endif
            end
        end else begin
            check_eq("rsp_valid_idle", 32'(bus.rsp_valid), 32'd0);
        end
        check_eq("cmp_count", 32'(cmp_count), 32'(exp_cnt));
        if (g >= 0) begin
            q.push_back('{g, (opnd(a, g) > opnd(b, g)), cyc + 2});
            last = g;
        end
        cyc++;
    endtask

    // Assert reset mid-cycle, check cleared outputs, then release.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_eq("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check_eq("rst_rsp_c", 32'(bus.rsp_c), 32'd0);
        check_eq("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
        check_eq("rst_cmp_count", 32'(cmp_count), 32'd0);
        q.delete();
        last    = N - 1;
        exp_cnt = '0;
        bus.req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [N*W-1:0] ra, rb;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        do_reset();

        // Single requester 0: 200 > 100.
        step(4'b0001, 32'd200, 32'd100, 1'b1);
        for (int i = 0; i < 3; i++) step(4'b0000, 32'd0, 32'd0, 1'b1);

        // Requester 2: equal operands, then a < b.
        step(4'b0100, 32'd50 << 16, 32'd50 << 16, 1'b1);
        for (int i = 0; i < 3; i++) step(4'b0000, 32'd0, 32'd0, 1'b1);
        step(4'b0100, 32'd10 << 16, 32'd90 << 16, 1'b1);
        for (int i = 0; i < 3; i++) step(4'b0000, 32'd0, 32'd0, 1'b1);

        // Reset to put the pointer back, then all requesters continuously.
        do_reset();
        for (int i = 0; i < 16; i++) step(4'b1111, $urandom, $urandom, 1'b1);
        for (int i = 0; i < 3; i++) step(4'b0000, 32'd0, 32'd0, 1'b1);

        // Backpressure: hold response five cycles with all requests pending.
        step(4'b1111, 32'hFF00_FF00, 32'h00FF_00FF, 1'b1);
        step(4'b1111, $urandom, $urandom, 1'b1);
        for (int i = 0; i < 5; i++) step(4'b1111, $urandom, $urandom, 1'b0);
        step(4'b1111, $urandom, $urandom, 1'b1);
        for (int i = 0; i < 3; i++) step(4'b0000, 32'd0, 32'd0, 1'b1);

        // Reset while in COMPARE: response discarded, next grant to 0.
        step(4'b0010, 32'd9 << 8, 32'd1 << 8, 1'b1);
        do_reset();
        step(4'b1111, $urandom, $urandom, 1'b1);
        for (int i = 0; i < 3; i++) step(4'b0000, 32'd0, 32'd0, 1'b1);

        // Randomized traffic with occasional equal operands and stalls.
        for (int i = 0; i < 400; i++) begin
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 7) == 0) rb = ra;
            step(N'($urandom_range(0, 15)), ra, rb, ($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 6; i++) step(4'b0000, 32'd0, 32'd0, 1'b1);

        @(negedge clk);
        #1;
`ifdef COMPARADOR_ARB_STATS_EN
        check_eq("final_count", 32'(cmp_count), 32'(exp_cnt));
`else
        check_eq("final_count", 32'(cmp_count), 32'd0);
`endif
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
